// File: rtl/ldpc_varnode.sv
// LDPC variable node: accumulates channel + DEGREE check messages, then emits extrinsics and a hard decision.
// Optional LDPC_VARNODE_SAT_EN: symmetric saturation of extrinsics instead of two's-complement wrap.
module ldpc_varnode #(
    parameter int DEGREE    = 6,
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 12
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_chan_llr,
    input  logic             i_chan_valid,
    output logic             o_chan_ready,
    input  logic [WIDTH-1:0] i_c2v_data,
    input  logic             i_c2v_valid,
    output logic             o_c2v_ready,
    output logic [WIDTH-1:0] o_v2c_data,
    output logic             o_v2c_valid,
    input  logic             i_v2c_ready,
    output logic             o_v2c_last,
    output logic             o_hard_bit,
    output logic             o_hard_valid
);
    // state  | meaning
    // IDLE   | waiting for the channel LLR
    // ACCUM  | collecting DEGREE check-to-variable messages
    // EMIT   | streaming DEGREE extrinsic messages
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_EMIT} state_t;

    localparam int IDX_W = (DEGREE > 1) ? $clog2(DEGREE) : 1;

    state_t                       state, state_nxt;
    logic        [IDX_W-1:0]      idx;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  acc_sum;
    logic signed [ACC_WIDTH-1:0]  chan_ext;
    logic signed [ACC_WIDTH-1:0]  c2v_ext;
    logic        [WIDTH-1:0]      buffer [DEGREE];
    logic        [WIDTH-1:0]      ext;
    logic                         chan_xfer, c2v_xfer, v2c_xfer, idx_last;

    assign chan_xfer = i_chan_valid && (state == S_IDLE);
    assign c2v_xfer  = i_c2v_valid  && (state == S_ACCUM);
    assign v2c_xfer  = i_v2c_ready  && (state == S_EMIT);
    assign idx_last  = (idx == IDX_W'(DEGREE - 1));

    assign chan_ext = {{(ACC_WIDTH-WIDTH){i_chan_llr[WIDTH-1]}}, i_chan_llr};
    assign c2v_ext  = {{(ACC_WIDTH-WIDTH){i_c2v_data[WIDTH-1]}}, i_c2v_data};
    assign acc_sum  = acc + c2v_ext;

`ifdef LDPC_VARNODE_SAT_EN
    localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'(2**(WIDTH-1) - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = -SAT_MAX;
    localparam logic        [WIDTH-1:0]   EXT_MAX = WIDTH'(2**(WIDTH-1) - 1);
    localparam logic        [WIDTH-1:0]   EXT_MIN = -EXT_MAX;

    logic signed [ACC_WIDTH:0] diff;

    always_comb begin
        diff = {acc[ACC_WIDTH-1], acc} - {{(ACC_WIDTH+1-WIDTH){buffer[idx][WIDTH-1]}}, buffer[idx]};
        if (diff > SAT_MAX) begin
            ext = EXT_MAX;
        end else if (diff < SAT_MIN) begin
            ext = EXT_MIN;
        end else begin
            ext = diff[WIDTH-1:0];
        end
    end
`else
    // Only the low WIDTH bits survive a wrapping subtraction, so compute just those.
    always_comb begin
        ext = acc[WIDTH-1:0] - buffer[idx];
    end
`endif

    assign o_chan_ready = (state == S_IDLE);
    assign o_c2v_ready  = (state == S_ACCUM);
    assign o_v2c_valid  = (state == S_EMIT);
    assign o_v2c_last   = (state == S_EMIT) && idx_last;
    assign o_v2c_data   = (state == S_EMIT) ? ext : '0;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (chan_xfer)             state_nxt = S_ACCUM;
            S_ACCUM: if (c2v_xfer && idx_last)  state_nxt = S_EMIT;
            S_EMIT:  if (v2c_xfer && idx_last)  state_nxt = S_IDLE;
            default:                            state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            idx          <= '0;
            o_hard_bit   <= 1'b0;
            o_hard_valid <= 1'b0;
        end else begin
            o_hard_valid <= 1'b0;
            if (chan_xfer) begin
                idx <= '0;
            end
            if (c2v_xfer) begin
                idx <= idx_last ? '0 : idx + IDX_W'(1);
                if (idx_last) begin
                    o_hard_valid <= 1'b1;
                    o_hard_bit   <= acc_sum[ACC_WIDTH-1];
                end
            end
            if (v2c_xfer) begin
                idx <= idx_last ? '0 : idx + IDX_W'(1);
            end
        end
    end

    // Datapath storage is fully rewritten for every node, so it carries no reset.
    always_ff @(posedge i_clock) begin
        if (chan_xfer) begin
            acc <= chan_ext;
        end
        if (c2v_xfer) begin
            acc         <= acc_sum;
            buffer[idx] <= i_c2v_data;
        end
    end

endmodule

// File: tb/tb_ldpc_varnode.sv
// Self-checking bench for ldpc_varnode: directed nodes checked against a behavioural extrinsic model.
module tb_ldpc_varnode;
    localparam int DEG = 6;
    localparam int W   = 8;
    localparam int AW  = 12;

    typedef int vec_t [DEG];

    logic         i_clock = 1'b0;
    logic         i_reset = 1'b1;
    logic [W-1:0] i_chan_llr = '0;
    logic         i_chan_valid = 1'b0;
    logic         o_chan_ready;
    logic [W-1:0] i_c2v_data = '0;
    logic         i_c2v_valid = 1'b0;
    logic         o_c2v_ready;
    logic [W-1:0] o_v2c_data;
    logic         o_v2c_valid;
    logic         i_v2c_ready = 1'b1;
    logic         o_v2c_last;
    logic         o_hard_bit;
    logic         o_hard_valid;

    ldpc_varnode #(.DEGREE(DEG), .WIDTH(W), .ACC_WIDTH(AW)) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_chan_llr   (i_chan_llr),
        .i_chan_valid (i_chan_valid),
        .o_chan_ready (o_chan_ready),
        .i_c2v_data   (i_c2v_data),
        .i_c2v_valid  (i_c2v_valid),
        .o_c2v_ready  (o_c2v_ready),
        .o_v2c_data   (o_v2c_data),
        .o_v2c_valid  (o_v2c_valid),
        .i_v2c_ready  (i_v2c_ready),
        .o_v2c_last   (o_v2c_last),
        .o_hard_bit   (o_hard_bit),
        .o_hard_valid (o_hard_valid)
    );

    always #5 i_clock = ~i_clock;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int exp_data [$];
    bit exp_last [$];
    bit exp_hard [$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int reduce(input int v);
        int lim, r;
        lim = (1 << (W - 1)) - 1;
`ifdef LDPC_VARNODE_SAT_EN
        r = (v > lim) ? lim : ((v < -lim) ? -lim : v);
`else
        r = v & ((1 << W) - 1);
        if (r > lim) r = r - (1 << W);
`endif
        return r;
    endfunction

    function automatic void model_node(input int chan, input vec_t c2v,
                                       output vec_t ext, output bit hard);
        int total;
        total = chan;
        foreach (c2v[i]) total += c2v[i];
        foreach (c2v[i]) ext[i] = reduce(total - c2v[i]);
        hard = (total < 0);
    endfunction

    // Checks every meaningful output cycle; pops on the cycle a handshake will occur.
    always @(negedge i_clock) begin
        if (chk_en) begin
            if (o_v2c_valid === 1'b1) begin
                if (exp_data.size() == 0) begin
                    check("v2c_unexpected", 1, 0);
                end else begin
                    check("v2c_data", int'($signed(o_v2c_data)), exp_data[0]);
                    check("v2c_last", int'(o_v2c_last), int'(exp_last[0]));
                    if (i_v2c_ready) begin
                        void'(exp_data.pop_front());
                        void'(exp_last.pop_front());
                    end
                end
            end
            if (o_hard_valid === 1'b1) begin
                if (exp_hard.size() == 0) begin
                    check("hard_unexpected", 1, 0);
                end else begin
                    check("hard_bit", int'(o_hard_bit), int'(exp_hard[0]));
                    void'(exp_hard.pop_front());
                end
            end
        end
    end

    task automatic send_chan(input int v);
        int n = 0;
        i_chan_llr   = W'(v);
        i_chan_valid = 1'b1;
        while (!o_chan_ready && n < 20) begin
            @(posedge i_clock); #1; n++;
        end
        check("chan_ready_timeout", int'(n < 20), 1);
        @(posedge i_clock); #1;
        i_chan_valid = 1'b0;
    endtask

    task automatic send_c2v(input int v);
        int n = 0;
        i_c2v_data  = W'(v);
        i_c2v_valid = 1'b1;
        while (!o_c2v_ready && n < 20) begin
            @(posedge i_clock); #1; n++;
        end
        check("c2v_ready_timeout", int'(n < 20), 1);
        @(posedge i_clock); #1;
        i_c2v_valid = 1'b0;
    endtask

    task automatic run_node(input int chan, input vec_t c2v, input bit stall, input bit chan_noise);
        vec_t ext;
        bit   hard;
        int   n = 0;
        model_node(chan, c2v, ext, hard);
        foreach (ext[i]) begin
            exp_data.push_back(ext[i]);
            exp_last.push_back(i == DEG - 1);
        end
        exp_hard.push_back(hard);
        send_chan(chan);
        if (chan_noise) begin
            i_chan_llr   = W'(55);
            i_chan_valid = 1'b1;
        end
        foreach (c2v[i]) send_c2v(c2v[i]);
        i_chan_valid = 1'b0;
        if (stall) begin
            @(posedge i_clock); #1;
            @(posedge i_clock); #1;
            i_v2c_ready = 1'b0;
            repeat (3) begin
                check("stall_data", int'($signed(o_v2c_data)), ext[2]);
                check("stall_valid", int'(o_v2c_valid), 1);
                check("stall_last", int'(o_v2c_last), 0);
                @(posedge i_clock); #1;
            end
            i_v2c_ready = 1'b1;
        end
        while ((exp_data.size() > 0 || exp_hard.size() > 0) && n < 100) begin
            @(posedge i_clock); #1; n++;
        end
        check("drain_timeout", int'(n < 100), 1);
        check("idle_after_node", int'(o_chan_ready), 1);
    endtask

    initial begin
        vec_t c_a, c_b, c_c, c_z, c_m, e_a, got;
        bit   h;

        c_a = '{5, -3, 2, 1, -4, 6};
        c_b = '{-1, -1, -1, -1, -1, -1};
        c_c = '{50, 50, 50, 50, 50, 50};
        c_z = '{-1, -1, -1, -1, -1, -1};
        c_m = '{-128, -128, -128, -128, -128, -128};

        repeat (2) @(posedge i_clock);
        #1;
        i_reset = 1'b0;
        check("rst_chan_ready", int'(o_chan_ready), 1);
        check("rst_c2v_ready", int'(o_c2v_ready), 0);
        check("rst_v2c_valid", int'(o_v2c_valid), 0);
        check("rst_v2c_last", int'(o_v2c_last), 0);
        check("rst_v2c_data", int'(o_v2c_data), 0);
        check("rst_hard_bit", int'(o_hard_bit), 0);
        check("rst_hard_valid", int'(o_hard_valid), 0);
        chk_en = 1'b1;

        e_a = '{12, 20, 15, 16, 21, 11};
        model_node(10, c_a, got, h);
        foreach (got[i]) check("model_pin_a", got[i], e_a[i]);
        check("model_pin_a_hard", int'(h), 0);
        model_node(-20, c_b, got, h);
        check("model_pin_b", got[0], -25);
        check("model_pin_b_hard", int'(h), 1);
        model_node(100, c_c, got, h);
`ifdef LDPC_VARNODE_SAT_EN
        check("model_pin_c", got[3], 127);
`else
        check("model_pin_c", got[3], 94);
`endif

        run_node(10, c_a, 1'b0, 1'b0);
        run_node(-20, c_b, 1'b0, 1'b0);

        // Abandon a node mid-accumulation.
        send_chan(30);
        for (int i = 0; i < 3; i++) send_c2v(7);
        i_reset = 1'b1;
        @(posedge i_clock); #1;
        i_reset = 1'b0;
        check("abort_chan_ready", int'(o_chan_ready), 1);
        check("abort_c2v_ready", int'(o_c2v_ready), 0);
        check("abort_v2c_valid", int'(o_v2c_valid), 0);
        check("abort_hard_valid", int'(o_hard_valid), 0);
        check("abort_hard_bit", int'(o_hard_bit), 0);
        repeat (4) @(posedge i_clock);
        #1;

        run_node(10, c_a, 1'b1, 1'b0);
        run_node(100, c_c, 1'b0, 1'b0);
        run_node(6, c_z, 1'b0, 1'b0);
        run_node(-128, c_m, 1'b0, 1'b0);

        // Check messages offered while idle must not be consumed.
        i_c2v_data  = W'(77);
        i_c2v_valid = 1'b1;
        repeat (3) begin
            @(posedge i_clock); #1;
            check("idle_c2v_ready", int'(o_c2v_ready), 0);
        end
        i_c2v_valid = 1'b0;
        run_node(10, c_a, 1'b0, 1'b1);

        repeat (3) @(posedge i_clock);
        #1;
        check("queues_empty", exp_data.size() + exp_hard.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d checks expected completion", checks);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ldpc_varnode.md
LDPC_VARNODE -- requirements
Module: ldpc_varnode

Interface
REQ-001 The block SHALL have parameter DEGREE, default 6, meaning the number of check-to-variable messages per variable node (range 2..8).
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning the two's-complement LLR width.
REQ-003 The block SHALL have parameter ACC_WIDTH, default 12, meaning the internal accumulator width (at least WIDTH+4).
REQ-004 i_clock  input  1  clock; all state SHALL update on its rising edge.
REQ-005 i_reset  input  1  reset, synchronous, active-high.
REQ-006 i_chan_llr  input  WIDTH  signed channel LLR.
REQ-007 i_chan_valid  input  1  channel LLR valid.
REQ-008 o_chan_ready  output  1  block accepts a channel LLR.
REQ-009 i_c2v_data  input  WIDTH  signed check-to-variable message.
REQ-010 i_c2v_valid  input  1  message valid.
REQ-011 o_c2v_ready  output  1  block accepts a message.
REQ-012 o_v2c_data  output  WIDTH  signed extrinsic variable-to-check message.
REQ-013 o_v2c_valid  output  1  extrinsic message valid.
REQ-014 i_v2c_ready  input  1  downstream accepts a message.
REQ-015 o_v2c_last  output  1  high with the message for index DEGREE-1.
REQ-016 o_hard_bit  output  1  hard decision; 1 when the posterior total is negative.
REQ-017 o_hard_valid  output  1  one-cycle strobe qualifying o_hard_bit.

Function
REQ-018 A transfer on any channel SHALL occur only in a cycle where valid and ready are both high.
REQ-019 The block SHALL implement the FSM IDLE -> ACCUM -> EMIT -> IDLE.
REQ-020 In IDLE, o_chan_ready=1 and o_c2v_ready=0; a channel transfer SHALL load the accumulator with sign-extended i_chan_llr, clear the index counter, and enter ACCUM.
REQ-021 In ACCUM, o_c2v_ready=1 and o_chan_ready=0; each transfer SHALL store the message in buffer[index], add it sign-extended to the accumulator, and increment the index.
REQ-022 The DEGREE-th ACCUM transfer SHALL enter EMIT with the index cleared.
REQ-023 On the cycle after the DEGREE-th transfer, o_hard_valid SHALL pulse for exactly one cycle, with o_hard_bit = sign of the total; a total of 0 SHALL give o_hard_bit = 0.
REQ-024 In EMIT, o_v2c_valid=1 and o_v2c_data = total - buffer[index], reduced to WIDTH bits per REQ-035/036.
REQ-025 Each EMIT transfer SHALL increment the index; the transfer with o_v2c_last=1 SHALL return to IDLE.
REQ-026 o_v2c_valid SHALL go high on the cycle after the DEGREE-th c2v transfer, giving a latency of 1 cycle.
REQ-027 With i_v2c_ready low, o_v2c_data, o_v2c_last and o_v2c_valid SHALL hold stable.
REQ-028 o_c2v_ready SHALL be 0 and c2v inputs SHALL be ignored outside ACCUM.
REQ-029 Channel inputs SHALL be ignored outside IDLE.
REQ-030 The accumulator SHALL never wrap, because ACC_WIDTH bounds the sum of DEGREE+1 WIDTH-bit values.

Reset
REQ-031 Reset SHALL force state IDLE and clear the index.
REQ-032 Reset SHALL force o_v2c_valid=0, o_v2c_last=0, o_hard_bit=0, o_hard_valid=0, o_c2v_ready=0 and o_v2c_data=0.
REQ-033 Reset SHALL force o_chan_ready=1 from the first cycle after reset.
REQ-034 Reset asserted mid-ACCUM or mid-EMIT SHALL abandon the node with no further outputs; buffer contents need no reset.

Configuration
REQ-035 With macro LDPC_VARNODE_SAT_EN defined, each extrinsic SHALL clamp symmetrically to [-(2^(WIDTH-1)-1), +(2^(WIDTH-1)-1)], i.e. [-127, +127] for WIDTH=8.
REQ-036 With LDPC_VARNODE_SAT_EN undefined, each extrinsic SHALL be the low WIDTH bits of the difference (wrap).

Verification
REQ-037 Scenario: chan=+10, c2v={+5,-3,+2,+1,-4,+6}, i_v2c_ready=1 -> hard_bit=0 and v2c={12,20,15,16,21,11}, with last on 11.
REQ-038 Scenario: chan=-20, c2v={-1,-1,-1,-1,-1,-1} -> total -26, hard_bit=1, all six v2c=-25.
REQ-039 Scenario: chan=+100, c2v six of +50 -> total 400, all v2c 127 with LDPC_VARNODE_SAT_EN; all v2c 94 (350 mod 256) without it.
REQ-040 Scenario: REQ-037 stimulus with i_v2c_ready low for 3 cycles at index 2 -> o_v2c_data holds 15 for those cycles, then the sequence resumes.
REQ-041 Scenario: reset asserted after 3 c2v transfers -> next cycle has o_chan_ready=1 and no v2c or hard outputs; a new node then processes correctly.
REQ-042 Scenario: c2v_valid high while in IDLE, and chan_valid high during ACCUM -> neither is consumed and results are unchanged.
